// File: rtl/xif_timer.sv
// ============================================================================
// Module  : xif_timer
// Purpose : 32-bit prescaled timer/compare peripheral on the xif split bus,
//           with one-shot/periodic modes and a level interrupt.
// Option  : XIF_TIMER_BE_EN - honour bus_be_bi byte enables on writes.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module xif_timer #(
    parameter logic [31:0] BASE_ADDR   = 32'h8000_1000,
    parameter int          PRESC_WIDTH = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        bus_req_i,
    output logic        bus_ack_o,
    input  logic        bus_we_i,
    input  logic [31:0] bus_addr_bi,
    input  logic [3:0]  bus_be_bi,
    input  logic [31:0] bus_wdata_bi,
    output logic        bus_resp_o,
    output logic [31:0] bus_rdata_bo,
    output logic        irq_o
);

    localparam logic [PRESC_WIDTH-1:0] PCNT_ONE = PRESC_WIDTH'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic [2:0]             ctrl_q, ctrl_d;
    logic [PRESC_WIDTH-1:0] presc_q, presc_d;
    logic [PRESC_WIDTH-1:0] pcnt_q, pcnt_d;
    logic [31:0]            count_q, count_d;
    logic [31:0]            cmp_q, cmp_d;
    logic                   match_q, match_d;
    logic                   resp_q, resp_d;
    logic [31:0]            rdata_q, rdata_d;

    logic        addr_hit, acc_rd, acc_wr;
    logic [2:0]  reg_sel;
    logic [31:0] be_mask;
    logic        be_any, be_w1c;
    logic        ctrl_we, count_we, w1c, tick, match_set;
    logic [31:0] presc_ext;
    logic        unused_in;

`ifdef XIF_TIMER_BE_EN
    assign be_mask   = {{8{bus_be_bi[3]}}, {8{bus_be_bi[2]}},
                        {8{bus_be_bi[1]}}, {8{bus_be_bi[0]}}};
    assign be_any    = |bus_be_bi;
    assign be_w1c    = bus_be_bi[0];
    assign unused_in = ^bus_addr_bi[1:0];
`else
    assign be_mask   = '1;
    assign be_any    = 1'b1;
    assign be_w1c    = 1'b1;
    assign unused_in = ^{bus_be_bi, bus_addr_bi[1:0]};
`endif

    assign bus_ack_o    = bus_req_i;
    assign bus_resp_o   = resp_q;
    assign bus_rdata_bo = rdata_q;
    assign irq_o        = match_q & ctrl_q[2];

    always_comb begin
        addr_hit  = (bus_addr_bi[31:5] == BASE_ADDR[31:5]);
        acc_rd    = bus_req_i & addr_hit & ~bus_we_i;
        acc_wr    = bus_req_i & addr_hit & bus_we_i;
        reg_sel   = bus_addr_bi[4:2];
        ctrl_we   = acc_wr & (reg_sel == 3'd0) & be_any;
        count_we  = acc_wr & (reg_sel == 3'd2);
        w1c       = acc_wr & (reg_sel == 3'd4) & be_w1c & bus_wdata_bi[0];
        tick      = (state_q == ST_RUN) && (pcnt_q >= presc_q);
        match_set = tick & ~count_we & (count_q == cmp_q);
        presc_ext = '0;
        presc_ext[PRESC_WIDTH-1:0] = presc_q;
    end

    always_comb begin
        state_d = state_q;
        ctrl_d  = ctrl_q;
        presc_d = presc_q;
        pcnt_d  = pcnt_q;
        count_d = count_q;
        cmp_d   = cmp_q;
        resp_d  = acc_rd;
        rdata_d = '0;

        if (acc_rd) begin
            case (reg_sel)
                3'd0:    rdata_d = {29'd0, ctrl_q};
                3'd1:    rdata_d = presc_ext;
                3'd2:    rdata_d = count_q;
                3'd3:    rdata_d = cmp_q;
                3'd4:    rdata_d = {31'd0, match_q};
                default: rdata_d = '0;
            endcase
        end

        if (state_q == ST_RUN) begin
            pcnt_d = tick ? '0 : pcnt_q + PCNT_ONE;
        end

        // A software COUNT write in a tick cycle suppresses both increment and compare
        if (tick && !count_we) begin
            if (count_q == cmp_q) begin
                if (ctrl_q[1]) begin
                    count_d = '0;
                end else begin
                    ctrl_d[0] = 1'b0;
                    state_d   = ST_DONE;
                end
            end else begin
                count_d = count_q + 32'd1;
            end
        end

        match_d = (match_q & ~w1c) | match_set;

        if (acc_wr && reg_sel == 3'd1) begin
            presc_d = (presc_q & ~be_mask[PRESC_WIDTH-1:0])
                    | (bus_wdata_bi[PRESC_WIDTH-1:0] & be_mask[PRESC_WIDTH-1:0]);
        end
        if (count_we) begin
            count_d = (count_q & ~be_mask) | (bus_wdata_bi & be_mask);
        end
        if (acc_wr && reg_sel == 3'd3) begin
            cmp_d = (cmp_q & ~be_mask) | (bus_wdata_bi & be_mask);
        end

        // CTRL write overrides any one-shot auto-clear in the same cycle
        if (ctrl_we) begin
            ctrl_d = (ctrl_q & ~be_mask[2:0]) | (bus_wdata_bi[2:0] & be_mask[2:0]);
            if (ctrl_d[0]) begin
                if (state_q != ST_RUN) begin
                    pcnt_d = '0;
                end
                state_d = ST_RUN;
            end else begin
                state_d = ST_IDLE;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            ctrl_q  <= '0;
            presc_q <= '0;
            pcnt_q  <= '0;
            count_q <= '0;
            cmp_q   <= '0;
            match_q <= 1'b0;
            resp_q  <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_d;
            presc_q <= presc_d;
            pcnt_q  <= pcnt_d;
            count_q <= count_d;
            cmp_q   <= cmp_d;
            match_q <= match_d;
            resp_q  <= resp_d;
            rdata_q <= rdata_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_xif_timer.sv
// ============================================================================
// Module  : tb_xif_timer
// Purpose : Directed self-checking bench for xif_timer with a cycle model.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_xif_timer;

    localparam int          PW     = 16;
    localparam logic [31:0] BASE   = 32'h8000_1000;
    localparam logic [31:0] PMASK  = 32'hFFFF_FFFF >> (32 - PW);
    localparam logic [31:0] A_CTRL = BASE + 32'h00;
    localparam logic [31:0] A_PRSC = BASE + 32'h04;
    localparam logic [31:0] A_CNT  = BASE + 32'h08;
    localparam logic [31:0] A_CMP  = BASE + 32'h0C;
    localparam logic [31:0] A_STAT = BASE + 32'h10;
`ifdef XIF_TIMER_BE_EN
    localparam bit BE_EN = 1'b1;
`else
    localparam bit BE_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        bus_req_i = 1'b0;
    logic        bus_ack_o;
    logic        bus_we_i = 1'b0;
    logic [31:0] bus_addr_bi = '0;
    logic [3:0]  bus_be_bi = 4'hF;
    logic [31:0] bus_wdata_bi = '0;
    logic        bus_resp_o;
    logic [31:0] bus_rdata_bo;
    logic        irq_o;

    int n_vec  = 0;
    int n_fail = 0;

    xif_timer #(.BASE_ADDR(BASE), .PRESC_WIDTH(PW)) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .bus_req_i   (bus_req_i),
        .bus_ack_o   (bus_ack_o),
        .bus_we_i    (bus_we_i),
        .bus_addr_bi (bus_addr_bi),
        .bus_be_bi   (bus_be_bi),
        .bus_wdata_bi(bus_wdata_bi),
        .bus_resp_o  (bus_resp_o),
        .bus_rdata_bo(bus_rdata_bo),
        .irq_o       (irq_o)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    logic [2:0]  m_ctrl = '0;
    logic [31:0] m_presc = '0, m_count = '0, m_cmp = '0, m_rdata = '0;
    bit          m_match = 1'b0, m_run = 1'b0, m_resp = 1'b0;
    longint      m_elapsed = 0;
    bit          e_hit, e_wr, e_cnt_wr, e_was_run, e_set, e_clr;
    logic [2:0]  e_sel;
    logic [31:0] e_tmp;

    function automatic logic [31:0] bmerge(input logic [31:0] o, input logic [31:0] d,
                                           input logic [3:0] be);
        logic [31:0] r;
        logic [3:0]  eb;
        eb = BE_EN ? be : 4'hF;
        r  = o;
        for (int i = 0; i < 4; i++) if (eb[i]) r[8*i +: 8] = d[8*i +: 8];
        return r;
    endfunction

    function automatic logic [31:0] m_read(input logic [2:0] s);
        case (s)
            3'd0:    return {29'd0, m_ctrl};
            3'd1:    return m_presc;
            3'd2:    return m_count;
            3'd3:    return m_cmp;
            3'd4:    return {31'd0, m_match};
            default: return 32'd0;
        endcase
    endfunction

    always @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            m_ctrl = '0; m_presc = '0; m_count = '0; m_cmp = '0;
            m_match = 0; m_run = 0; m_elapsed = 0; m_resp = 0; m_rdata = '0;
        end else begin
            e_hit     = bus_req_i && (bus_addr_bi[31:5] == BASE[31:5]);
            e_wr      = e_hit && bus_we_i;
            e_sel     = bus_addr_bi[4:2];
            m_resp    = e_hit && !bus_we_i;
            m_rdata   = m_resp ? m_read(e_sel) : 32'd0;
            e_cnt_wr  = e_wr && e_sel == 3'd2;
            e_was_run = m_run;
            e_set     = 0;
            // ticks fall on every (PRESC+1)-th cycle spent running
            if (m_run) begin
                if ((m_elapsed % (longint'(m_presc) + 1)) == longint'(m_presc) && !e_cnt_wr) begin
                    if (m_count == m_cmp) begin
                        e_set = 1;
                        if (m_ctrl[1]) m_count = 0;
                        else begin m_ctrl[0] = 0; m_run = 0; end
                    end else begin
                        m_count = m_count + 1;
                    end
                end
                m_elapsed++;
            end
            e_clr   = e_wr && e_sel == 3'd4 && bus_wdata_bi[0] && (!BE_EN || bus_be_bi[0]);
            m_match = e_set || (m_match && !e_clr);
            if (e_wr) begin
                case (e_sel)
                    3'd0: if (!BE_EN || bus_be_bi != 4'd0) begin
                        e_tmp  = bmerge({29'd0, m_ctrl}, bus_wdata_bi, bus_be_bi);
                        m_ctrl = e_tmp[2:0];
                        if (m_ctrl[0]) begin
                            if (!e_was_run) m_elapsed = 0;
                            m_run = 1;
                        end else begin
                            m_run = 0;
                        end
                    end
                    3'd1: m_presc = bmerge(m_presc, bus_wdata_bi, bus_be_bi) & PMASK;
                    3'd2: m_count = bmerge(m_count, bus_wdata_bi, bus_be_bi);
                    3'd3: m_cmp   = bmerge(m_cmp, bus_wdata_bi, bus_be_bi);
                    default: ;
                endcase
            end
        end
    end

    // Every-cycle comparison of all DUT outputs against the model
    always @(negedge clk) begin
        n_vec++;
        if (bus_resp_o !== m_resp || bus_rdata_bo !== m_rdata ||
            irq_o !== (m_match & m_ctrl[2]) || bus_ack_o !== bus_req_i) begin
            n_fail++;
            $display("FAIL cycle_cmp t=%0t: resp/rdata/irq/ack got %b/%h/%b/%b expected %b/%h/%b/%b",
                     $time, bus_resp_o, bus_rdata_bo, irq_o, bus_ack_o,
                     m_resp, m_rdata, m_match & m_ctrl[2], bus_req_i);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic bus_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be = 4'hF);
        bus_req_i = 1; bus_we_i = 1; bus_addr_bi = a; bus_wdata_bi = d; bus_be_bi = be;
        @(posedge clk); #1;
        bus_req_i = 0; bus_we_i = 0; bus_be_bi = 4'hF;
    endtask

    task automatic bus_rd(input logic [31:0] a, output logic [31:0] d, output logic got);
        bus_req_i = 1; bus_we_i = 0; bus_addr_bi = a;
        @(posedge clk); #1;
        bus_req_i = 0;
        got = bus_resp_o;
        d   = bus_rdata_bo;
    endtask

    task automatic rd_chk(input string name, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] d;
        logic        g;
        bus_rd(a, d, g);
        chk({name, "_resp"}, {31'd0, g}, 32'd1);
        chk(name, d, exp);
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic edges_to_irq(input int limit, output int k);
        k = 0;
        while (!irq_o && k < limit) begin @(posedge clk); #1; k++; end
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int          k;
        logic [31:0] d1, d2, d3;
        logic        g;

        repeat (3) @(posedge clk);
        #1 rst_i = 0;
        idle(1);

        // reset values, back-to-back reads
        chk("irq_reset", {31'd0, irq_o}, 32'd0);
        rd_chk("ctrl_rst",  A_CTRL, 32'd0);
        rd_chk("presc_rst", A_PRSC, 32'd0);
        rd_chk("count_rst", A_CNT,  32'd0);
        rd_chk("cmp_rst",   A_CMP,  32'd0);
        rd_chk("stat_rst",  A_STAT, 32'd0);

        // one-shot with prescaler 3, compare 4
        bus_wr(A_PRSC, 32'd3);
        bus_wr(A_CMP,  32'd4);
        bus_wr(A_CTRL, 32'h5);
        edges_to_irq(100, k);
        chk("oneshot_latency", k, 32'd20);
        rd_chk("oneshot_count", A_CNT,  32'd4);
        rd_chk("oneshot_ctrl",  A_CTRL, 32'h4);
        idle(10);
        rd_chk("oneshot_frozen", A_CNT, 32'd4);
        rd_chk("oneshot_stat",   A_STAT, 32'd1);

        // periodic, prescaler 0, compare 2
        bus_wr(A_STAT, 32'h1);
        chk("w1c_drop", {31'd0, irq_o}, 32'd0);
        bus_wr(A_CNT,  32'd0);
        bus_wr(A_PRSC, 32'd0);
        bus_wr(A_CMP,  32'd2);
        bus_wr(A_CTRL, 32'h7);
        edges_to_irq(50, k);
        chk("periodic_latency", k, 32'd3);
        bus_wr(A_STAT, 32'h1);
        chk("periodic_w1c_drop", {31'd0, irq_o}, 32'd0);
        edges_to_irq(50, k);
        chk("periodic_reassert", k, 32'd2);
        bus_rd(A_CNT, d1, g);
        bus_rd(A_CNT, d2, g);
        bus_rd(A_CNT, d3, g);
        chk("periodic_seq1", d2, (d1 + 1) % 3);
        chk("periodic_seq2", d3, (d2 + 1) % 3);
        bus_wr(A_CTRL, 32'h0);
        bus_wr(A_STAT, 32'h1);

        // 32-bit wrap without a match
        bus_wr(A_CNT, 32'hFFFF_FFFE);
        bus_wr(A_CMP, 32'd5);
        bus_wr(A_CTRL, 32'h1);
        idle(1);
        rd_chk("wrap_ff", A_CNT, 32'hFFFF_FFFF);
        rd_chk("wrap_00", A_CNT, 32'h0);
        rd_chk("wrap_nomatch", A_STAT, 32'd0);
        idle(10);
        rd_chk("wrap_match", A_STAT, 32'd1);
        rd_chk("wrap_count", A_CNT, 32'd5);
        rd_chk("wrap_ctrl", A_CTRL, 32'd0);

        // W1C colliding with a periodic match: set wins
        bus_wr(A_STAT, 32'h1);
        bus_wr(A_CNT, 32'd0);
        bus_wr(A_CMP, 32'd2);
        bus_wr(A_CTRL, 32'h3);
        idle(2);
        bus_wr(A_STAT, 32'h1);
        rd_chk("w1c_vs_set", A_STAT, 32'd1);
        bus_wr(A_CTRL, 32'h0);

        // window boundaries
        rd_chk("hole_14", BASE + 32'h14, 32'd0);
        rd_chk("hole_1c", BASE + 32'h1C, 32'd0);
        bus_rd(BASE + 32'h40, d1, g);
        chk("miss_noresp", {31'd0, g}, 32'd0);
        bus_wr(BASE + 32'h2C, 32'h1234);
        rd_chk("miss_nowrite", A_CMP, 32'd2);

        // byte enables
        bus_wr(A_CMP, 32'd0);
        bus_wr(A_CMP, 32'hAABB_CCDD, 4'b0010);
        rd_chk("cmp_be", A_CMP, BE_EN ? 32'h0000_CC00 : 32'hAABB_CCDD);

        // asynchronous reset mid-run with a read in flight
        bus_wr(A_CMP, 32'hFFFF_0000);
        bus_wr(A_CTRL, 32'h1);
        idle(5);
        bus_req_i = 1; bus_we_i = 0; bus_addr_bi = A_CNT;
        #2 rst_i = 1;
        @(posedge clk); #1;
        chk("rst_resp", {31'd0, bus_resp_o}, 32'd0);
        rst_i = 0; bus_req_i = 0;
        idle(2);
        rd_chk("rst_count", A_CNT,  32'd0);
        rd_chk("rst_ctrl",  A_CTRL, 32'd0);
        rd_chk("rst_cmp",   A_CMP,  32'd0);
        idle(3);
        rd_chk("rst_frozen", A_CNT, 32'd0);

        idle(2);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/xif_timer.md
Name: xif_timer

Overview:
- Memory-mapped 32-bit timer/compare peripheral on the tile's external (xif) split-bus port, beside the LED/switch CSR decoder.
- Produces a level interrupt that feeds a tile interrupt input (irq_debounced_bi bit chosen at integration).
- Supports prescaled counting, compare match, one-shot and periodic modes.
- Software-visible through five word registers.

Parameters:
- BASE_ADDR, 32'h80001000, word-aligned base of the 32-byte register window.
- PRESC_WIDTH, 16, width of the prescaler register and prescaler counter (1..32).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset; asynchronous, active-high
- bus_req_i  in  1  xif request
- bus_ack_o  out  1  request accepted; equals bus_req_i combinationally
- bus_we_i  in  1  1 = write, 0 = read
- bus_addr_bi  in  32  byte address
- bus_be_bi  in  4  byte enables
- bus_wdata_bi  in  32  write data
- bus_resp_o  out  1  read response strobe, one-cycle pulse
- bus_rdata_bo  out  32  read data; 0 when bus_resp_o = 0
- irq_o  out  1  level interrupt = STATUS.MATCH & CTRL.IRQ_EN

Behaviour:
- Reset values: all registers 0, state IDLE, bus_resp_o = 0, bus_rdata_bo = 0, irq_o = 0.
- Address decode: hit when bus_addr_bi[31:5] == BASE_ADDR[31:5].
  - Offsets: 0x00 CTRL, 0x04 PRESC, 0x08 COUNT, 0x0C CMP, 0x10 STATUS.
  - Other offsets inside the window: reads return 0 with resp; writes are ignored.
  - Misses produce no resp and no side effect.
- Register fields:
  - CTRL: bit0 EN, bit1 PERIODIC, bit2 IRQ_EN; other bits read 0.
  - PRESC: PRESC_WIDTH bits; other bits read 0.
  - STATUS: bit0 MATCH, write-1-to-clear.
- Read: the access is accepted in cycle N; bus_resp_o = 1 and data are valid in cycle N+1 for exactly one cycle. Back-to-back reads give back-to-back responses. Writes produce no resp.
- Tick generation: the prescaler counter increments each cycle while in RUN. When it reaches PRESC, it resets to 0 and emits a tick. Tick period is PRESC+1 cycles.
- FSM:
  - IDLE: counter frozen. Writing CTRL with EN=1 goes to RUN and clears the prescaler counter.
  - RUN: on each tick, COUNT increments by 1 and wraps mod 2^32 with no flag. If CMP == COUNT at that tick, MATCH is set, then:
    - PERIODIC=1: COUNT <= 0 and the FSM stays in RUN.
    - PERIODIC=0: COUNT is held, EN auto-clears, and the FSM goes to DONE.
  - RUN, CTRL write with EN=0: go to IDLE, COUNT held.
  - DONE: behaves as IDLE (frozen). Writing EN=1 goes to RUN.
- Compare is evaluated on the pre-increment COUNT value at the tick. CMP=0 with COUNT=0 therefore matches on the first tick.
- Simultaneous events:
  - A software COUNT write in the same cycle as a tick: the write wins, no increment, no match evaluation that cycle, prescaler counter cleared.
  - STATUS W1C in the same cycle as a new match: MATCH remains 1 (set wins).
  - A CTRL write in the same cycle as a one-shot auto-clear: the written value wins.
- rst_i asserted mid-operation immediately returns every register, FSM state and output to reset values, including a pending resp.

Optional Feature:
- Macro: XIF_TIMER_BE_EN.
- Defined: writes update only the bytes whose bus_be_bi bit is 1. A W1C to STATUS takes effect only if bus_be_bi[0] = 1.
- Undefined: bus_be_bi is ignored and every write is a full 32-bit write.

Test Plan:
- Reset then read all five offsets → resp one cycle after each read, all data 0, irq_o = 0.
- PRESC=3, CMP=4, CTRL=0x5 (EN, one-shot, IRQ_EN) → MATCH and irq_o rise 20 cycles after the CTRL write. COUNT reads 4, CTRL reads 0x4, FSM frozen.
- PRESC=0, CMP=2, CTRL=0x7 → irq_o first rises 3 cycles after the write. COUNT cycles 0,1,2,0,… Writing 0x1 to STATUS drops irq_o the next cycle, and it reasserts 3 cycles later.
- COUNT=0xFFFFFFFE, CMP=5, PRESC=0, CTRL=0x1 → COUNT wraps to 0 with no MATCH, then MATCH when COUNT reaches 5.
- STATUS W1C issued on the exact cycle of a periodic match → MATCH reads 1. Read of BASE+0x14 → resp with 0. Read of BASE+0x40 → no resp.
- With XIF_TIMER_BE_EN: write 0xAABBCCDD to CMP with be=4'b0010 → CMP reads 0x0000CC00. Without the macro → CMP reads 0xAABBCCDD.
